// File: rtl/reg_file_sb.sv
// Register file with two async read ports, one sync write port and R0 tied to zero.
// Each register has a pending-write counter. Define RF_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module rfSlot #(
  parameter int DATA_W = 16,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrHit,
  input  logic [DATA_W-1:0] wrData,
  input  logic              incHit,
  output logic [DATA_W-1:0] data,
  output logic [PEND_W-1:0] pend
);
  logic decHit;
  assign decHit = wrHit && (pend != '0);

  // incHit is only raised while pend is below saturation, so the counter cannot wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      pend <= '0;
    end else begin
      if (wrHit) data <= wrData;
      if (incHit && !decHit)      pend <= pend + PEND_W'(1);
      else if (!incHit && decHit) pend <= pend - PEND_W'(1);
    end
  end
endmodule

module reg_file_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              issue_ready,
  output logic              src1_busy,
  output logic              src2_busy,
  output logic              sb_err
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0][PEND_W-1:0] pend;
  logic wrLive, issueLive, busy1, busy2;

  assign wrLive      = wr_en && (wr_addr != '0);
  assign issue_ready = (issue_dst == '0) || (pend[issue_dst] != PEND_MAX);
  assign issueLive   = issue_en && issue_ready && (issue_dst != '0);

  assign regs[0] = '0;
  assign pend[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : gSlot
    rfSlot #(.DATA_W(DATA_W), .PEND_W(PEND_W)) uSlot (
      .clk    (clk),
      .rst    (rst),
      .wrHit  (wrLive && (wr_addr == ADDR_W'(i))),
      .wrData (wr_data),
      .incHit (issueLive && (issue_dst == ADDR_W'(i))),
      .data   (regs[i]),
      .pend   (pend[i])
    );
  end

  // Writeback to a register nobody issued; the data write still goes through
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               sb_err <= 1'b0;
    else if (wrLive && pend[wr_addr] == '0) sb_err <= 1'b1;
  end

  assign busy1 = (rd_addr1 != '0) && (pend[rd_addr1] != '0);
  assign busy2 = (rd_addr2 != '0) && (pend[rd_addr2] != '0);

`ifdef RF_BYPASS_EN
  logic hit1, hit2;
  assign hit1 = wr_en && (wr_addr == rd_addr1) && (rd_addr1 != '0);
  assign hit2 = wr_en && (wr_addr == rd_addr2) && (rd_addr2 != '0);

  assign rd_data1  = hit1 ? wr_data : regs[rd_addr1];
  assign rd_data2  = hit2 ? wr_data : regs[rd_addr2];
  // The final outstanding write retiring this cycle clears the hazard early
  assign src1_busy = busy1 && !(hit1 && pend[rd_addr1] == PEND_W'(1));
  assign src2_busy = busy2 && !(hit2 && pend[rd_addr2] == PEND_W'(1));
`else
  assign rd_data1  = regs[rd_addr1];
  assign rd_data2  = regs[rd_addr2];
  assign src1_busy = busy1;
  assign src2_busy = busy2;
`endif
endmodule
